// File: rtl/alu_src_mux_pipe.sv
// Registered ALU operand select: picks a register operand or an extended immediate
// and delivers it through a 2-entry skid buffer with a valid/ready handshake.
module alu_src_mux_pipe #(
  parameter int WIDTH   = 32,
  parameter int NUM_SRC = 4,
  parameter int IMM_W   = 16,
  localparam int SEL_W  = $clog2(NUM_SRC + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SEL_W-1:0]         ALUSrc,
  input  logic [NUM_SRC*WIDTH-1:0] mux_in,
  input  logic [IMM_W-1:0]         imm_in,
  input  logic                     imm_sext,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         mux_out,
  output logic                     sel_err
);

  localparam logic [SEL_W-1:0] IMM_SEL = SEL_W'(NUM_SRC);

  logic [WIDTH-1:0] imm_ext;
  logic [WIDTH-1:0] sel_data;
  logic             sel_bad;

  logic             main_valid, skid_valid;
  logic [WIDTH-1:0] main_data, skid_data;
  logic             main_err, skid_err;
  logic             accept, drain;

  generate
    if (IMM_W < WIDTH) begin : g_ext
      assign imm_ext = {{(WIDTH-IMM_W){imm_sext & imm_in[IMM_W-1]}}, imm_in};
    end else begin : g_noext
      assign imm_ext = imm_in;
    end
  endgenerate

  // Selects above NUM_SRC yield zero data and raise the error flag instead of aliasing.
  always_comb begin
    sel_data = '0;
    sel_bad  = 1'b0;
    if (ALUSrc == IMM_SEL) begin
      sel_data = imm_ext;
    end else if (ALUSrc > IMM_SEL) begin
      sel_bad = 1'b1;
    end else begin
      for (int k = 0; k < NUM_SRC; k++) begin
        if (ALUSrc == SEL_W'(k)) sel_data = mux_in[k*WIDTH +: WIDTH];
      end
    end
  end

  assign in_ready  = !skid_valid;
  assign accept    = in_valid && in_ready;
  assign drain     = main_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      main_err   <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_err   <= 1'b0;
    end else begin
      if (drain && skid_valid) begin
        // in_ready is low whenever the skid is full, so no accept can collide here
        main_data  <= skid_data;
        main_err   <= skid_err;
        skid_valid <= 1'b0;
      end else if (accept && (!main_valid || drain)) begin
        main_valid <= 1'b1;
        main_data  <= sel_data;
        main_err   <= sel_bad;
      end else if (accept) begin
        skid_valid <= 1'b1;
        skid_data  <= sel_data;
        skid_err   <= sel_bad;
      end else if (drain) begin
        main_valid <= 1'b0;
      end
    end
  end

  assign out_valid = main_valid;
  assign mux_out   = main_data;
  assign sel_err   = main_err;

endmodule

// File: tb/tb_alu_src_mux_pipe.sv
// Self-checking bench for alu_src_mux_pipe: directed scenarios plus random traffic
// compared against a queue-based reference of the operand select and buffer.
module tb_alu_src_mux_pipe;
  localparam int WIDTH = 32;
  localparam int NUM_SRC = 4;
  localparam int IMM_W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   ALUSrc;
  logic [127:0] mux_in;
  logic [15:0]  imm_in;
  logic         imm_sext;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  mux_out;
  logic         sel_err;

  int n_checks = 0;
  int n_fail = 0;
  int n_drained = 0;
  bit last_acc;
  logic [32:0] q[$];

  alu_src_mux_pipe #(.WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .IMM_W(IMM_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ALUSrc(ALUSrc), .mux_in(mux_in), .imm_in(imm_in), .imm_sext(imm_sext),
    .out_valid(out_valid), .out_ready(out_ready), .mux_out(mux_out), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  // Reference select: {err, data}
  function automatic logic [32:0] ref_sel(int sel, logic [127:0] m, logic [15:0] imm, bit sx);
    if (sel < 4) return {1'b0, 32'(m >> (32 * sel))};
    if (sel == 4) return {1'b0, (sx && imm >= 16'h8000) ? (32'hFFFF0000 | 32'(imm)) : 32'(imm)};
    return {1'b1, 32'h0};
  endfunction

  // Advance one clock and update the model: front of q is the word the outputs must show.
  task automatic advance();
    bit acc, drn;
    acc = in_valid && (q.size() < 2);
    drn = (q.size() > 0) && out_ready;
    if (drn) begin
      void'(q.pop_front());
      n_drained++;
    end
    if (acc) q.push_back(ref_sel(int'(ALUSrc), mux_in, imm_in, imm_sext));
    last_acc = acc;
    @(negedge clk);
  endtask

  task automatic rand_word();
    ALUSrc = 3'($urandom_range(0, 7));
    mux_in = {$urandom, $urandom, $urandom, $urandom};
    imm_in = 16'($urandom);
    imm_sext = 1'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b0;
    rand_word();
    repeat (2) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || mux_out !== 32'h0 || sel_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b d=%h e=%b want 0/0/0", out_valid, mux_out, sel_err);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    q.delete();
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_passthrough();
    mux_in = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    ALUSrc = 3'd2;
    in_valid = 1'b1;
    out_ready = 1'b1;
    advance();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || mux_out !== 32'h33333333 || sel_err !== 1'b0) begin
      n_fail++;
      $display("FAIL passthrough: got v=%b d=%h e=%b want 1/33333333/0", out_valid, mux_out, sel_err);
    end
    advance();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL passthrough_drain: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_imm();
    out_ready = 1'b1;
    in_valid = 1'b1;
    ALUSrc = 3'd4;
    imm_in = 16'h8001;
    imm_sext = 1'b1;
    advance();
    n_checks++;
    if (mux_out !== 32'hFFFF8001 || sel_err !== 1'b0 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL imm_sext: got %h e=%b want FFFF8001 e=0", mux_out, sel_err);
    end
    imm_sext = 1'b0;
    advance();
    n_checks++;
    if (mux_out !== 32'h00008001 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL imm_zext: got %h want 00008001", mux_out);
    end
    in_valid = 1'b0;
    advance();
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    in_valid = 1'b1;
    mux_in = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    ALUSrc = 3'd5;
    advance();
    n_checks++;
    if (mux_out !== 32'h0 || sel_err !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_sel5: got %h e=%b want 00000000 e=1", mux_out, sel_err);
    end
    ALUSrc = 3'd1;
    advance();
    n_checks++;
    if (mux_out !== 32'h22222222 || sel_err !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_then_legal: got %h e=%b want 22222222 e=0", mux_out, sel_err);
    end
    ALUSrc = 3'd7;
    advance();
    n_checks++;
    if (mux_out !== 32'h0 || sel_err !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_sel7: got %h e=%b want 00000000 e=1", mux_out, sel_err);
    end
    in_valid = 1'b0;
    advance();
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_seq[5];
    mux_in = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
    out_ready = 1'b0;
    in_valid = 1'b1;
    ALUSrc = 3'd0;
    advance();
    ALUSrc = 3'd1;
    advance();
    ALUSrc = 3'd3;
    // A held through the stall while B sits in the skid and C waits upstream
    exp_seq = '{32'hAAAA0000, 32'hAAAA0000, 32'hBBBB0001, 32'hDDDD0003, 32'h0};
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (mux_out !== exp_seq[i] || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_stall%0d: got d=%h v=%b rdy=%b want %h v=1 rdy=0", i, mux_out, out_valid, in_ready, exp_seq[i]);
      end
      advance();
    end
    out_ready = 1'b1;
    advance();
    n_checks++;
    if (mux_out !== exp_seq[2] || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_B: got d=%h rdy=%b want %h rdy=1", mux_out, in_ready, exp_seq[2]);
    end
    advance();
    in_valid = 1'b0;
    n_checks++;
    if (mux_out !== exp_seq[3] || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_C: got d=%h v=%b want %h v=1", mux_out, out_valid, exp_seq[3]);
    end
    advance();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_empty: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_throughput();
    int start;
    start = n_drained;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      rand_word();
      ALUSrc = 3'($urandom_range(0, 4));
      advance();
      n_checks++;
      if (out_valid !== 1'b1 || q.size() != 1 || {sel_err, mux_out} !== q[0]) begin
        n_fail++;
        $display("FAIL throughput[%0d]: got v=%b %b_%h want v=1 %h", i, out_valid, sel_err, mux_out, q[0]);
      end
    end
    in_valid = 1'b0;
    advance();
    n_checks++;
    if (n_drained - start != 100 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL throughput_count: got %0d v=%b want 100 v=0", n_drained - start, out_valid);
    end
  endtask

  task automatic test_random_traffic();
    in_valid = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!in_valid || last_acc) begin
        in_valid = 1'($urandom_range(0, 3) != 0);
        rand_word();
      end
      out_ready = 1'($urandom_range(0, 2) != 0);
      advance();
      n_checks++;
      if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2) ||
          (q.size() > 0 && {sel_err, mux_out} !== q[0])) begin
        n_fail++;
        $display("FAIL random[%0d]: got v=%b rdy=%b %b_%h want occupancy %0d front %h", i, out_valid, in_ready, sel_err, mux_out, q.size(), (q.size() > 0) ? q[0] : 33'h0);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) advance();
  endtask

  task automatic test_reset_mid_stall();
    out_ready = 1'b0;
    in_valid = 1'b1;
    mux_in = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    ALUSrc = 3'd3;
    advance();
    ALUSrc = 3'd2;
    advance();
    in_valid = 1'b0;
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || mux_out !== 32'h44444444) begin
      n_fail++;
      $display("FAIL rst_stall_full: got rdy=%b v=%b d=%h want 0/1/44444444", in_ready, out_valid, mux_out);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || mux_out !== 32'h0 || sel_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_async: got v=%b d=%h e=%b want 0/0/0", out_valid, mux_out, sel_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_release: got rdy=%b v=%b want 1/0", in_ready, out_valid);
    end
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      advance();
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_no_replay%0d: got out_valid=%b want 0", i, out_valid);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    ALUSrc = '0;
    mux_in = '0;
    imm_in = '0;
    imm_sext = 1'b0;
    last_acc = 1'b0;
    test_reset();
    test_passthrough();
    test_imm();
    test_illegal();
    test_backpressure();
    test_throughput();
    test_random_traffic();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_src_mux_pipe.md
Name: alu_src_mux_pipe

Overview:
- Parametrised, registered successor to the single-cycle ALU operand select mux.
- Selects one of NUM_SRC register-path operands, or a sign- or zero-extended immediate, and registers the result.
- Output sits behind a 2-entry skid buffer with valid/ready handshake, so ALU operand selection can sit in a pipelined datapath stage.
- Out-of-range selects are flagged rather than silently aliased.

Parameters:
- WIDTH, 32, operand/result width in bits.
- NUM_SRC, 4, number of register-path operand inputs (>=2).
- IMM_W, 16, immediate field width (IMM_W <= WIDTH).
- SEL_W, clog2(NUM_SRC+1), derived localparam: select width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  block can accept a word this cycle.
- ALUSrc  in  SEL_W  source select: 0..NUM_SRC-1 picks mux_in slice k; NUM_SRC picks extended immediate; >NUM_SRC is illegal.
- mux_in  in  NUM_SRC*WIDTH  flattened operands, slice k = bits [k*WIDTH +: WIDTH].
- imm_in  in  IMM_W  immediate field.
- imm_sext  in  1  1 = sign-extend imm_in, 0 = zero-extend.
- out_valid  out  1  mux_out/sel_err valid.
- out_ready  in  1  downstream accepts.
- mux_out  out  WIDTH  selected operand, registered.
- sel_err  out  1  word carried an illegal ALUSrc; registered, travels with its word.

Behaviour:
- Reset (async, rst_n=0):
  - main and skid valid flags clear.
  - mux_out=0, sel_err=0, out_valid=0.
  - in_ready=1 as soon as rst_n deasserts; it is not required to be high while rst_n=0.
  - Reset mid-transfer discards both held words; nothing is replayed.
- Select (combinational, pre-register):
  - ALUSrc<NUM_SRC: data = slice ALUSrc.
  - ALUSrc==NUM_SRC: data = imm_in extended to WIDTH per imm_sext.
  - ALUSrc>NUM_SRC: data = 0, err = 1.
  - err=0 otherwise.
- Accept = in_valid && in_ready. Drain = out_valid && out_ready.
- Storage: main register (drives outputs) and skid register, each with a valid flag.
- Rules per clock edge:
  - Accept with main empty, or with Drain and skid empty: word goes to main.
  - Accept with main full and no Drain: word goes to skid.
  - Drain with skid full: skid moves to main and skid clears. Any Accept is impossible that cycle because in_ready=0.
  - Drain, no Accept, skid empty: main valid clears; mux_out/sel_err hold their last value.
- in_ready = !skid_valid, decoded from a register only, with no combinational path from out_ready.
- Latency: 1 cycle from Accept to out_valid when the buffer is empty.
- Throughput: 1 word/cycle sustained while out_ready=1.
- Stall stability: while out_valid=1 and out_ready=0, mux_out and sel_err are stable.
- Ordering: words leave in acceptance order; no drop, no duplication.
- Inputs ALUSrc/mux_in/imm_in/imm_sext are sampled only on Accept; they are don't-care otherwise.
- Both storage entries full: in_ready=0. in_valid is ignored and must be held by upstream.

Test Plan:
- Reset then passthrough: WIDTH=32, NUM_SRC=4, mux_in slices 0x11111111/0x22222222/0x33333333/0x44444444, ALUSrc=2, in_valid=1, out_ready=1 -> next cycle out_valid=1, mux_out=0x33333333, sel_err=0; all outputs 0 while rst_n=0.
- Immediate extension: imm_in=0x8001, ALUSrc=4, imm_sext=1 -> mux_out=0xFFFF8001; same with imm_sext=0 -> 0x00008001.
- Illegal select: ALUSrc=5 -> mux_out=0x00000000, sel_err=1 for that word only; following legal word has sel_err=0.
- Backpressure:
  - Stimulus: stream A, B, C (ALUSrc 0, 1, 3) with out_ready=0.
  - A is held stable on mux_out and B is taken into skid; in_ready=0 after the second accept and C is held upstream.
  - Release out_ready -> outputs A, B, C in order, no loss.
- Full throughput: 100 words, random ALUSrc 0..4, out_ready=1 -> 100 outputs on 100 consecutive cycles after 1-cycle latency, matching the reference model.
- Async reset mid-stall: both entries full, pull rst_n low between clock edges -> out_valid=0 and mux_out=0 immediately without a clock edge; after release in_ready=1 and the held words are not emitted.
